ram_bist: RTL and testbench
===========================

Name: ram_bist

Overview:
- Built-in self-test sequencer that sits directly upstream of the 32x32 single-port RAM.
- Drives the RAM's cen/wen/addr/din and consumes its registered dout.
- Writes an address-dependent pattern to every word, then reads every word back and compares.
- Reports pass/fail, the error count and the first failing address; used at bring-up and in field diagnostics.

Parameters:
- AW, 5, address width; the sweep covers 0..2^AW-1.
- DW, 32, data width.
- PATTERN, 32'hA5A5_5A5A, base data pattern.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a test; sampled only in IDLE
- cen  output  1  RAM chip enable
- wen  output  1  RAM write enable (1 = write, 0 = read)
- addr  output  AW  RAM address
- din  output  DW  RAM write data
- ram_dout  input  DW  RAM registered read data
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse
- pass  output  1  result of the last completed test; held until the next start
- err_cnt  output  7  number of mismatching reads in the last test
- fail_addr  output  AW  address of the first mismatch; 0 if none

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0 (cen=0, wen=0, addr=0, din=0, busy=0, done=0, pass=0, err_cnt=0, fail_addr=0); state IDLE.
- Reset mid-test: same values on the next edge. The test is abandoned and no done pulse is issued.
- Registered outputs: all outputs are registered.
- Pattern: data(a) = PATTERN ^ {2'b00, {6{a}}}. Example: data(7) = 32'hABD6_C6BD.
- States: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE: cen=0. If start=1 at edge E, then at E:
  - state goes to WRITE; busy=1;
  - err_cnt, fail_addr and pass are cleared;
  - cen=1, wen=1, addr=0, din=data(0) are registered.
- WRITE: one write per cycle, address incrementing.
  - After address 31 is presented, the next edge (E+32) presents READ address 0: cen=1, wen=0, din=0.
- READ: one read per cycle, address incrementing.
  - After address 31 (edge E+63) the next edge enters DRAIN with cen=0, wen=0.
- Compare pipeline: 2-stage expected/valid pipe matching the RAM's 1-cycle registered read.
  - Read address a is presented after edge E+32+a.
  - The RAM samples it at E+33+a.
  - ram_dout is compared against data(a) at edge E+34+a.
  - On a mismatch: err_cnt increments; fail_addr latches a only on the first mismatch.
- DRAIN: holds for 2 cycles (edges E+64, E+65) so the last compare retires, then moves to FINISH.
- FINISH (edge E+66):
  - done=1 for exactly one cycle;
  - pass = (err_cnt==0);
  - busy=0;
  - return to IDLE.
- start handling: start is ignored in every state except IDLE. A start pulse coincident with the FINISH edge is ignored.
- Address wrap: the address counter stops at 31. There is no wrap-around access and no out-of-range address is ever issued.
- Counter width: err_cnt is 7 bits, covering at most 64 compares with the optional feature, so it never overflows.

Optional Feature:
- Macro: RAM_BIST_INV_PASS_EN.
- When defined: after the first DRAIN, a second WRITE/READ/DRAIN pass runs with data ~data(a).
  - First write of pass 2 is presented after edge E+66.
  - done pulses at edge E+132.
  - err_cnt and fail_addr accumulate across both passes; fail_addr is still the first mismatch overall.
- When undefined: single pass, and done pulses at edge E+66.

Test Plan:
- Clean RAM attached, start at E → busy=1 from E; 32 writes then 32 reads; done at E+66; pass=1, err_cnt=0, fail_addr=0. RAM word 7 reads 32'hABD6_C6BD.
- Bench forces ram_dout[0] inverted for the read of address 5 → pass=0, err_cnt=1, fail_addr=5.
- Forced errors on addresses 9 and 20 → err_cnt=2, fail_addr=9.
- rst=1 at E+40 → next edge: cen=0, busy=0, done never pulses. A new start then completes with pass=1 at start+66.
- start pulsed at E+10 and at E+66 → both ignored; exactly one done pulse; second test runs only on a later start from IDLE.
- With RAM_BIST_INV_PASS_EN: clean RAM → done at E+132, pass=1. RAM word 7 ends at 32'h5429_3942. A fault only on the inverted read of address 3 → err_cnt=1, fail_addr=3.

Source files
------------

// File: rtl/ram_bist.sv
// BIST sequencer for the 32x32 single-port RAM: write pattern sweep, read-back compare.
// Optional macro RAM_BIST_INV_PASS_EN adds a second sweep with inverted data.
module ram_bist #(
  parameter int unsigned     AW      = 5,
  parameter int unsigned     DW      = 32,
  parameter logic [DW-1:0]   PATTERN = 32'hA5A5_5A5A
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          cen,
  output logic          wen,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [6:0]    err_cnt,
  output logic [AW-1:0] fail_addr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [AW-1:0] ADDR_LAST = '1;

  logic [2:0]    state;
  logic          drain_cnt;
  logic          inv;
  logic [AW-1:0] addr_nxt;

  // Compare pipe: stage 1 tracks the presented read, stage 2 lines up with ram_dout.
  logic          v1, v2;
  logic [DW-1:0] e1, e2;
  logic [AW-1:0] a1, a2;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic flip);
    return (PATTERN ^ DW'({6{a}})) ^ {DW{flip}};
  endfunction

  assign addr_nxt = addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
      inv       <= 1'b0;
      cen       <= 1'b0;
      wen       <= 1'b0;
      addr      <= '0;
      din       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      e1        <= '0;
      e2        <= '0;
      a1        <= '0;
      a2        <= '0;
    end else begin
      done <= 1'b0;
      v1   <= 1'b0;
      v2   <= v1;
      e2   <= e1;
      a2   <= a1;

      if (v2 && (ram_dout != e2)) begin
        err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0)
          fail_addr <= a2;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WRITE;
            busy      <= 1'b1;
            err_cnt   <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
            inv       <= 1'b0;
            cen       <= 1'b1;
            wen       <= 1'b1;
            addr      <= '0;
            din       <= pat('0, 1'b0);
          end
        end

        S_WRITE: begin
          if (addr == ADDR_LAST) begin
            state <= S_READ;
            wen   <= 1'b0;
            din   <= '0;
            addr  <= '0;
            v1    <= 1'b1;
            e1    <= pat('0, inv);
            a1    <= '0;
          end else begin
            addr <= addr_nxt;
            din  <= pat(addr_nxt, inv);
          end
        end

        S_READ: begin
          if (addr == ADDR_LAST) begin
            state     <= S_DRAIN;
            cen       <= 1'b0;
            wen       <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            addr <= addr_nxt;
            v1   <= 1'b1;
            e1   <= pat(addr_nxt, inv);
            a1   <= addr_nxt;
          end
        end

        S_DRAIN: begin
          if (!drain_cnt) begin
            drain_cnt <= 1'b1;
          end else begin
`ifdef RAM_BIST_INV_PASS_EN
            if (!inv) begin
              state <= S_WRITE;
              inv   <= 1'b1;
              cen   <= 1'b1;
              wen   <= 1'b1;
              addr  <= '0;
              din   <= pat('0, 1'b1);
            end else begin
              state <= S_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_cnt == '0);
            end
`else
            state <= S_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_cnt == '0);
`endif
          end
        end

        S_FINISH: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural 32x32 RAM and per-read fault injection.
module tb_ram_bist;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cen;
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] ram_dout;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  err_cnt;
  logic [4:0]  fail_addr;

  int total;
  int bad;

  logic [31:0]  mem [32];
  logic [127:0] fault_rd;
  int           rd_ord;

`ifdef RAM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int NDONE = 66 * NPASS;

  ram_bist #(.AW(5), .DW(32), .PATTERN(32'hA5A5_5A5A)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cen       (cen),
    .wen       (wen),
    .addr      (addr),
    .din       (din),
    .ram_dout  (ram_dout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read; fault_rd flips bit 0 on the n-th read of a test.
  always @(posedge clk) begin
    if (!busy) rd_ord <= 0;
    if (cen) begin
      if (wen) begin
        mem[addr] <= din;
      end else begin
        ram_dout <= mem[addr] ^ {31'b0, fault_rd[rd_ord]};
        rd_ord   <= rd_ord + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [4:0] a, input logic flip);
    logic [31:0] r;
    r = 32'hA5A5_5A5A ^ {2'b00, a, a, a, a, a, a};
    return flip ? ~r : r;
  endfunction

  // Start a test and check the bus cycle by cycle until the done pulse.
  task automatic run_test(input bit ign, input int exp_err, input logic [4:0] exp_fa,
                          input logic exp_pass);
    int p, j, dcnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= NDONE; k++) begin
      if (k < NDONE) begin
        p = k / 66;
        j = k % 66;
        if (j < 32)
          chk($sformatf("wr k=%0d", k), {cen, wen, addr, din},
              {1'b1, 1'b1, 5'(j), data_of(5'(j), p[0])});
        else if (j < 64)
          chk($sformatf("rd k=%0d", k), {cen, wen, addr, din},
              {1'b1, 1'b0, 5'(j - 32), 32'h0});
        else
          chk($sformatf("drain k=%0d", k), {cen, wen}, 2'b00);
        chk($sformatf("busy/done k=%0d", k), {busy, done}, 2'b10);
      end else begin
        chk("finish busy/done", {busy, done, cen, wen}, 4'b0100);
        chk("pass", pass, exp_pass);
        chk("err_cnt", err_cnt, 7'(exp_err));
        chk("fail_addr", fail_addr, exp_fa);
      end
      start = ign && ((k + 1 == 10) || (k + 1 == NDONE));
      if (k < NDONE) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    chk("done one cycle", done, 1'b0);
    chk("pass held", pass, exp_pass);
    if (ign) begin
      dcnt = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (done || busy) dcnt++;
      end
      chk("no retrigger", 64'(dcnt), 64'd0);
    end
  endtask

  initial begin
    int dcnt;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    fault_rd = '0;
    repeat (3) @(negedge clk);
    chk("reset outs", {cen, wen, addr, din, busy, done, pass, err_cnt, fail_addr}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", {cen, busy, done}, 3'b000);

    // Clean RAM
    run_test(1'b0, 0, 5'd0, 1'b1);
`ifdef RAM_BIST_INV_PASS_EN
    chk("mem7", mem[7], 32'h5429_3942);
`else
    chk("mem7", mem[7], 32'hABD6_C6BD);
`endif

    // Single forced error on the read of address 5
    fault_rd = '0;
    fault_rd[5] = 1'b1;
    run_test(1'b0, 1, 5'd5, 1'b0);

    // Two errors: first failing address must stick
    fault_rd = '0;
    fault_rd[9]  = 1'b1;
    fault_rd[20] = 1'b1;
    run_test(1'b0, 2, 5'd9, 1'b0);
    fault_rd = '0;

    // Reset mid-test abandons the run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort outs", {cen, wen, addr, din, busy, done, pass, err_cnt, fail_addr}, 64'h0);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("no done after abort", 64'(dcnt), 64'd0);
    run_test(1'b0, 0, 5'd0, 1'b1);

    // start pulses while busy and on the finish edge are ignored
    run_test(1'b1, 0, 5'd0, 1'b1);

`ifdef RAM_BIST_INV_PASS_EN
    // Fault only on the inverted-pass read of address 3
    fault_rd = '0;
    fault_rd[32 + 3] = 1'b1;
    run_test(1'b0, 1, 5'd3, 1'b0);
    fault_rd = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
